mem_stage_lsu: RTL

- MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs, performs data-memory accesses over a req/ack bus, and drives the MEM/WB register fields.
- Generates the pipeline `stall` while an access is outstanding.
- Covers RV32I byte, halfword and word loads and stores, including sign/zero extension and misalignment detection.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 60 ++++++
 rtl/mem_stage_lsu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lsu_state_t;

   // Stores only have the signed encodings; loads also take BU/HU.
   function automatic logic f3_legal(input logic [2:0] f3, input logic store);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and access checks.
module lsu_align import lsu_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic            rd_en,
   input  logic            wr_en,
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] store_data,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_offset,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic            illegal,
   output logic            misaligned,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be         = 4'h0;
      wdata      = store_data;
      misaligned = 1'b0;
      illegal    = (rd_en & wr_en) | ~f3_legal(funct3, wr_en);
      case (funct3)
         F3_B: begin
            be    = 4'b0001 << offset;
            wdata = {(XLEN/8){store_data[7:0]}};
         end
         F3_H: begin
            misaligned = offset[0];
            be         = 4'b0011 << offset;
            wdata      = {(XLEN/16){store_data[15:0]}};
         end
         F3_HU:   misaligned = offset[0];
         F3_W: begin
            misaligned = |offset;
            be         = 4'b1111;
         end
         default: be = 4'h0;
      endcase
      if (!wr_en) be = 4'b1111;
   end

   always_comb begin
      byte_sel = rdata[8*ld_offset +: 8];
      half_sel = ld_offset[1] ? rdata[31:16] : rdata[15:0];
      case (ld_funct3)
         F3_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses over a req/ack bus,
// stalls the pipeline while one is outstanding and drives the MEM/WB fields.
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops and faults pass in one cycle
// WAIT  | request on the bus, dmem_* held until dmem_ack
module mem_stage_lsu import lsu_pkg::*; #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_we,
   input  logic [RF_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]      mem_ALU_out,
   input  logic [XLEN-1:0]      mem_DataB,
   input  logic [XLEN-1:0]      mem_pc,
   input  logic                 mem_rd_en,
   input  logic                 mem_wr_en,
   input  logic [2:0]           mem_funct3,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [XLEN-1:0]      dmem_addr,
   output logic [XLEN-1:0]      dmem_wdata,
   output logic [3:0]           dmem_be,
   input  logic                 dmem_ack,
   input  logic [XLEN-1:0]      dmem_rdata,
   output logic                 stall,
   output logic                 wb_we,
   output logic [RF_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic [XLEN-1:0]      wb_pc,
   output logic                 mem_fault
);

   lsu_state_t           state;
   logic                 op;
   logic                 fault;
   logic                 illegal;
   logic                 misaligned;
   logic [3:0]           al_be;
   logic [XLEN-1:0]      al_wdata;
   logic [XLEN-1:0]      ld_data;
   logic [1:0]           lat_off;
   logic [2:0]           lat_f3;
   logic                 lat_load;
   logic                 lat_we;
   logic [RF_ADDR_W-1:0] lat_rd;
   logic [XLEN-1:0]      lat_pc;
   logic [XLEN-1:0]      lat_alu;

   lsu_align #(.XLEN(XLEN)) u_align (
      .rd_en      (mem_rd_en),
      .wr_en      (mem_wr_en),
      .funct3     (mem_funct3),
      .offset     (mem_ALU_out[1:0]),
      .store_data (mem_DataB),
      .ld_funct3  (lat_f3),
      .ld_offset  (lat_off),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .illegal    (illegal),
      .misaligned (misaligned),
      .ld_data    (ld_data)
   );

   assign op    = mem_rd_en | mem_wr_en;
   assign fault = op & (illegal | misaligned);
   // The ack cycle releases the pipeline so the next op enters IDLE right after.
   assign stall = (state == IDLE) ? (op & ~fault) : ~dmem_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= 4'h0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_pc      <= '0;
         mem_fault  <= 1'b0;
         lat_off    <= 2'b00;
         lat_f3     <= 3'b000;
         lat_load   <= 1'b0;
         lat_we     <= 1'b0;
         lat_rd     <= '0;
         lat_pc     <= '0;
         lat_alu    <= '0;
      end else begin
         mem_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (fault) begin
                  wb_we     <= 1'b0;
                  wb_pc     <= mem_pc;
                  mem_fault <= 1'b1;
               end else if (op) begin
                  state      <= WAIT;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_wr_en;
                  dmem_addr  <= {mem_ALU_out[XLEN-1:2], 2'b00};
                  dmem_be    <= al_be;
                  dmem_wdata <= al_wdata;
                  lat_off    <= mem_ALU_out[1:0];
                  lat_f3     <= mem_funct3;
                  lat_load   <= mem_rd_en;
                  lat_we     <= mem_we;
                  lat_rd     <= mem_rd;
                  lat_pc     <= mem_pc;
                  lat_alu    <= mem_ALU_out;
                  wb_we      <= 1'b0;
               end else begin
                  wb_we   <= mem_we;
                  wb_rd   <= mem_rd;
                  wb_data <= mem_ALU_out;
                  wb_pc   <= mem_pc;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= 4'h0;
                  wb_we    <= lat_we;
                  wb_rd    <= lat_rd;
                  wb_pc    <= lat_pc;
                  wb_data  <= lat_load ? ld_data : lat_alu;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
